// File: rtl/i2c_pkg.sv
// Shared encodings for the single-byte I2C master.
// Bus levels per state/phase live here so the FSM stays table-like.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_NACK,
    ST_STOP
  } state_e;

  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;

  localparam logic [6:0] SLAVE_ADDR_DEFAULT = 7'b1011011;

  // Returns {scl, sda_low} for a state, phase and outgoing data bit.
  function automatic logic [1:0] bus_level(
    input state_e     s,
    input logic [1:0] p,
    input logic       b
  );
    logic [1:0] lv;
    lv = 2'b10;
    unique case (s)
      ST_START:         lv = {1'b1, p[1]};
      ST_ADDR,
      ST_WRITE:         lv = {p[1], ~b};
      ST_ADDR_ACK,
      ST_WRITE_ACK,
      ST_READ,
      ST_READ_NACK:     lv = {p[1], 1'b0};
      ST_STOP:          lv = {p[1], p != P3};
      default:          lv = 2'b10;
    endcase
    return lv;
  endfunction

endpackage

// File: rtl/i2c_phase_gen.sv
// SCL quarter-phase divider: tick every CLK_DIV clks, 2-bit phase index.
// Held at phase 0 / count 0 while clr is high.
module i2c_phase_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && !clr && (cnt == CMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= P0;
    end else if (clr) begin
      cnt   <= '0;
      phase <= P0;
    end else if (en) begin
      if (cnt == CMAX) begin
        cnt   <= '0;
        phase <= phase + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_master_byte_ctrl.sv
// Single-byte I2C master: START, addr+R/W, ACK, one data byte, STOP.
// SDA trails SCL by one clk so data never moves on an SCL edge.
module i2c_master_byte_ctrl
  import i2c_pkg::*;
#(
  parameter int ADDR_LEN = 7,
  parameter int DATA_LEN = 8,
  parameter int CLK_DIV  = 4
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                rw,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic [DATA_LEN-1:0] wdata,
  output logic [DATA_LEN-1:0] rdata,
  output logic                busy,
  output logic                done,
  output logic                ack_err,
  output logic                scl,
  inout  wire                 sda
);

  localparam int SW =
    (ADDR_LEN + 1 > DATA_LEN) ? ADDR_LEN + 1 : DATA_LEN;
  localparam int CNTW = $clog2(SW);

  state_e              state;
  logic [SW-1:0]       sh;
  logic [CNTW-1:0]     bit_cnt;
  logic                rw_q;
  logic [DATA_LEN-1:0] wdata_q;
  logic                sda_pre;
  logic                sda_low;
  logic                tick;
  logic [1:0]          phase;
  logic                samp;
  logic                last;

  assign sda  = sda_low ? 1'b0 : 1'bz;
  assign samp = tick && (phase == P2);
  assign last = tick && (phase == P3);

  i2c_phase_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_phase (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state != ST_IDLE),
    .clr   (state == ST_IDLE),
    .tick  (tick),
    .phase (phase)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      sh      <= '0;
      bit_cnt <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      scl     <= 1'b1;
      sda_pre <= 1'b0;
      sda_low <= 1'b0;
    end else begin
      done <= 1'b0;
      {scl, sda_pre} <= bus_level(state, phase, sh[SW-1]);
      sda_low <= sda_pre;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            rw_q    <= rw;
            wdata_q <= wdata;
            sh      <= SW'({addr, rw}) << (SW - ADDR_LEN - 1);
            ack_err <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (last) begin
            bit_cnt <= CNTW'(ADDR_LEN);
            state   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (last) begin
            sh <= sh << 1;
            if (bit_cnt == '0) state <= ST_ADDR_ACK;
            else bit_cnt <= bit_cnt - 1'b1;
          end
        end
        ST_ADDR_ACK: begin
          if (samp && sda) ack_err <= 1'b1;
          if (last) begin
            bit_cnt <= CNTW'(DATA_LEN - 1);
            sh      <= SW'(wdata_q) << (SW - DATA_LEN);
            if (ack_err)   state <= ST_STOP;
            else if (rw_q) state <= ST_READ;
            else           state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (last) begin
            sh <= sh << 1;
            if (bit_cnt == '0) state <= ST_WRITE_ACK;
            else bit_cnt <= bit_cnt - 1'b1;
          end
        end
        ST_WRITE_ACK: begin
          if (samp && sda) ack_err <= 1'b1;
          if (last) state <= ST_STOP;
        end
        ST_READ: begin
          if (samp) sh <= {sh[SW-2:0], sda};
          if (last) begin
            if (bit_cnt == '0) state <= ST_READ_NACK;
            else bit_cnt <= bit_cnt - 1'b1;
          end
        end
        ST_READ_NACK: begin
          if (last) begin
            rdata <= sh[DATA_LEN-1:0];
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Bench for i2c_master_byte_ctrl: clocked slave model on a pulled-up bus,
// expected results queued at issue time and checked when done pulses.
module tb_i2c_master_byte_ctrl;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  wire  [7:0] rdata;
  wire        busy, done, ack_err, scl;
  wire        sda;

  logic slave_low = 1'b0;
  assign sda = slave_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_master_byte_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .rw      (rw),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .scl     (scl),
    .sda     (sda)
  );

  int passed = 0;
  int total = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Slave at SLAVE_ADDR_DEFAULT, sampled mid-low clk phase.
  typedef enum {S_IDLE, S_ADDR, S_AACK, S_WR, S_WACK, S_RD, S_MNACK} sst_e;
  sst_e       sst = S_IDLE;
  int         scnt = 0;
  int         stops = 0;
  logic [7:0] ssh = '0;
  logic [7:0] addr_rx = '0;
  logic [7:0] data_sent = '0;
  logic [7:0] slave_tx = 8'h3C;
  logic       rwbit = 1'b0;
  logic       nack_bit = 1'b0;
  logic       pscl = 1'b1;
  logic       psda = 1'b1;
  wire        rise = !pscl && scl;
  wire        fall = pscl && !scl;

  always @(negedge clk) begin
    pscl <= scl;
    psda <= sda;
    if (pscl && scl && psda && !sda) begin
      sst <= S_ADDR;
      scnt <= 0;
      slave_low <= 1'b0;
    end else if (pscl && scl && !psda && sda) begin
      sst <= S_IDLE;
      slave_low <= 1'b0;
      stops <= stops + 1;
    end else begin
      case (sst)
        S_ADDR:
          if (rise) begin
            ssh <= {ssh[6:0], sda};
            scnt <= scnt + 1;
          end else if (fall && scnt == 8) begin
            addr_rx <= ssh;
            if (ssh[7:1] == SLAVE_ADDR_DEFAULT) begin
              slave_low <= 1'b1;
              rwbit <= ssh[0];
              sst <= S_AACK;
            end else sst <= S_IDLE;
          end
        S_AACK:
          if (fall) begin
            scnt <= 0;
            if (rwbit) begin
              slave_low <= ~slave_tx[7];
              sst <= S_RD;
            end else begin
              slave_low <= 1'b0;
              sst <= S_WR;
            end
          end
        S_WR:
          if (rise) begin
            ssh <= {ssh[6:0], sda};
            scnt <= scnt + 1;
          end else if (fall && scnt == 8) begin
            data_sent <= ssh;
            slave_low <= 1'b1;
            sst <= S_WACK;
          end
        S_WACK:
          if (fall) begin
            slave_low <= 1'b0;
            sst <= S_IDLE;
          end
        S_RD:
          if (rise) scnt <= scnt + 1;
          else if (fall) begin
            if (scnt == 8) begin
              slave_low <= 1'b0;
              sst <= S_MNACK;
            end else slave_low <= ~slave_tx[7-scnt];
          end
        S_MNACK:
          if (rise) begin
            nack_bit <= sda;
            sst <= S_IDLE;
          end
        default: ;
      endcase
    end
  end

  typedef struct {
    logic       ack_err;
    logic [7:0] rdata;
    int         lat;
    int         rises;
    logic [7:0] abyte;
    logic       chk_wr;
    logic [7:0] wbyte;
    logic       chk_rd;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   ndone = 0;
  int   gap = 0;
  int   od_viol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin : monitor
    exp_t e;
    int   t0, rises, stops0, last_done;
    logic pb, ps;
    t0 = 0; rises = 0; stops0 = 0; last_done = 0;
    pb = 1'b0; ps = 1'b1;
    forever begin
      @(negedge clk);
      if (slave_low && sda !== 1'b0) od_viol++;
      if (busy && !pb) begin
        t0 = cyc;
        rises = 0;
        stops0 = stops;
      end else if (busy && scl && !ps) rises++;
      if (done) begin
        ndone++;
        gap = cyc - last_done;
        last_done = cyc;
        if (q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          check("ack_err", ack_err, e.ack_err);
          check("rdata", rdata, e.rdata);
          check("latency", cyc - t0, e.lat);
          check("scl_rises", rises, e.rises);
          check("addr_byte", addr_rx, e.abyte);
          check("stop_seen", stops - stops0, 1);
          check("busy_at_done", busy, 0);
          if (e.chk_wr) check("slave_data", data_sent, e.wbyte);
          if (e.chk_rd) check("master_nack", nack_bit, 1);
        end
      end
      pb = busy;
      ps = scl;
    end
  end

  function automatic exp_t mk(input logic ae, input logic [7:0] rd,
                              input int lat, input int rs,
                              input logic [7:0] ab, input logic cw,
                              input logic [7:0] wb, input logic cr);
    exp_t e;
    e.ack_err = ae; e.rdata = rd; e.lat = lat; e.rises = rs;
    e.abyte = ab; e.chk_wr = cw; e.wbyte = wb; e.chk_rd = cr;
    return e;
  endfunction

  task automatic issue(input logic [6:0] a, input logic r,
                       input logic [7:0] d);
    @(negedge clk);
    addr = a; rw = r; wdata = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n0;
    n0 = ndone;
    for (int i = 0; i < budget && ndone == n0; i++) @(negedge clk);
    if (ndone == n0) check("done_timeout", 0, 1);
  endtask

  initial begin
    #22;
    check("rst_scl", scl, 1);
    check("rst_sda", sda, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_rdata", rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // write 0xA5 to 0x5B
    q.push_back(mk(0, 8'h00, 320, 19, 8'hB6, 1, 8'hA5, 0));
    issue(7'h5B, 0, 8'hA5);
    wait_done(400);
    repeat (5) @(negedge clk);

    // read 0x3C from 0x5B
    q.push_back(mk(0, 8'h3C, 320, 19, 8'hB7, 0, 8'h00, 1));
    issue(7'h5B, 1, 8'h00);
    wait_done(400);
    repeat (5) @(negedge clk);

    // wrong address: NACK, no data phase, rdata kept
    q.push_back(mk(1, 8'h3C, 176, 10, 8'h54, 0, 8'h00, 0));
    issue(7'h2A, 0, 8'h11);
    wait_done(400);
    repeat (5) @(negedge clk);

    // start and wdata changes while busy are ignored
    q.push_back(mk(0, 8'h3C, 320, 19, 8'hB6, 1, 8'hC3, 0));
    issue(7'h5B, 0, 8'hC3);
    repeat (100) @(negedge clk);
    addr = 7'h2A; rw = 1'b1; wdata = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0; wdata = 8'hFF;
    wait_done(400);
    repeat (20) @(negedge clk);
    check("idle_after_ignored_start", busy, 0);

    // start held high: back-to-back transactions
    q.push_back(mk(0, 8'h3C, 320, 19, 8'hB6, 1, 8'h5A, 0));
    q.push_back(mk(0, 8'h3C, 320, 19, 8'hB6, 1, 8'h5A, 0));
    @(negedge clk);
    addr = 7'h5B; rw = 1'b0; wdata = 8'h5A; start = 1'b1;
    wait_done(400);
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done(400);
    check("b2b_gap", gap, 321);
    repeat (5) @(negedge clk);

    // reset during WRITE bit 3
    issue(7'h5B, 0, 8'hA5);
    repeat (228) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_scl", scl, 1);
    check("midrst_sda", sda, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_rdata", rdata, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    q.push_back(mk(0, 8'h00, 320, 19, 8'hB6, 1, 8'h96, 0));
    issue(7'h5B, 0, 8'h96);
    wait_done(400);
    repeat (10) @(negedge clk);

    check("open_drain_violations", od_viol, 0);
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/i2c_master_byte_ctrl.md
Name: i2c_master_byte_ctrl

Overview:
- Single-byte I2C master controller driving the `scl`/`sda` bus that our I2C slave FSM listens on.
- Runs from a system clock and derives SCL internally.
- On a request it performs one complete transaction: START, 7-bit address + R/W, address ACK check, one data byte (write or read), STOP.
- Results are returned to the local host through a pulse-style done/status interface.

Parameters:
- ADDR_LEN, 7, slave address width.
- DATA_LEN, 8, data byte width.
- CLK_DIV, 4, clk cycles per SCL quarter-phase. Must be ≥2. One SCL bit = 4*CLK_DIV clk cycles.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- rw  input  1  0 = write, 1 = read; captured with start.
- addr  input  ADDR_LEN  target slave address; captured with start.
- wdata  input  DATA_LEN  write byte; captured with start.
- rdata  output  DATA_LEN  byte received in a read; valid from done onward.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at transaction end.
- ack_err  output  1  valid with done; 1 = address or write-data NACK seen.
- scl  output  1  SCL, push-pull.
- sda  inout  DATA 1  open-drain. Driven 0 when sda_low is set, otherwise 'z'. Read back every bit.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, scl=1, sda released.
  - rdata=0, busy=0, done=0, ack_err=0, bit counter and divider cleared.
  - Reset mid-transfer releases the bus immediately; no STOP is generated.
- Phase timing:
  - A divider produces a tick every CLK_DIV clks and a 2-bit phase index p0..p3.
  - Data bits: SCL=0 in p0–p1 and 1 in p2–p3.
  - SDA is changed only at p0 entry.
  - SDA is sampled on the last clk of p2.
  - The divider is held at p0/count 0 in IDLE.
- States:
  - IDLE: scl=1, sda released. If start=1, capture rw/addr/wdata, clear ack_err, set busy, go to START.
  - START: p0–p1 SCL=1, SDA released. p2–p3 SCL=1, SDA driven low (START condition). Then ADDR.
  - ADDR: 8 bits, MSB first: addr[6:0] then rw. Bit counter 7 down to 0. Then ADDR_ACK.
  - ADDR_ACK: SDA released, sampled at p2.
    - Sample 1 → ack_err=1, go STOP.
    - Sample 0 → WRITE if rw=0, READ if rw=1.
  - WRITE: 8 bits of wdata, MSB first. Then WRITE_ACK.
  - WRITE_ACK: SDA released, sampled. Sample 1 sets ack_err=1. Always go to STOP.
  - READ: SDA released. Shift in 8 samples MSB first. Then READ_NACK.
  - READ_NACK: SDA released (master NACK = 1). Transfer the shift register to rdata. Go to STOP.
  - STOP:
    - p0–p1 SCL=0, SDA low.
    - p2 SCL=1, SDA low.
    - p3 SCL=1, SDA released (STOP condition).
    - On the p3 end tick, go to IDLE with done=1 for one clk and busy=0.
- Latency:
  - Write or read: 4 + 9*4 + 9*4 + 4 = 80 phases = 80*CLK_DIV clks (320 at default) from start acceptance to done.
  - Address NACK: 44*CLK_DIV clks.
- Boundary conditions:
  - start while busy: ignored; inputs not re-captured.
  - start held high through done: a new transaction starts on the cycle after return to IDLE.
  - rdata is unchanged by writes and by address-NACK transactions.
  - sda is never driven high.

Decomposition:
- Package i2c_pkg holds:
  - state encodings for IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_NACK, STOP;
  - phase constants P0–P3;
  - SLAVE_ADDR_DEFAULT = 7'b1011011.
- Sub-module i2c_phase_gen: the CLK_DIV divider producing tick and the phase index, with enable/clear.

Test Plan:
- Write:
  - Stimulus: addr=7'h5B, rw=0, wdata=8'hA5, bus connected to the slave FSM (address 1011011).
  - Required: SDA bits 1011011,0; ACK=0; then 10100101; ACK=0; STOP. done after 320 clks, ack_err=0. Slave data_sent=8'hA5.
- Read:
  - Stimulus: addr=7'h5B, rw=1, slave data_received=8'h3C.
  - Required: rdata=8'h3C at done, master NACK bit seen as SDA=1, ack_err=0, STOP seen.
- Wrong address:
  - Stimulus: addr=7'h2A.
  - Required: ADDR_ACK sample=1, ack_err=1 with done at 176 clks, no data clocks, STOP generated, rdata unchanged.
- Busy and retrigger:
  - start pulse during a write: no effect; wdata change mid-transfer not reflected on the bus.
  - start held high: two back-to-back transactions, done pulses 321 clks apart.
- Reset mid-transfer:
  - Stimulus: rst_n=0 during the WRITE bit 3.
  - Required: scl=1 and sda=z the same cycle; busy=0, done=0; a subsequent write completes normally.
- Open-drain check: bench pull-up model; assert the DUT never drives sda=1 throughout all of the above.
